// File: rtl/tag_store_ctrl_if.sv
// ---------------------------------------------------------------------------
// tag_store_ctrl_if
// Bus bundle between the L1 cache controller (master) and the tag store
// (slave).
//   Lookup:     lk_valid/lk_ready handshake with lk_index, lk_tag.
//   Result:     rs_valid strobe with rs_hit, rs_way, rs_victim.
//   Fill:       fill_en with fill_index, fill_way, fill_tag (no handshake).
//   Invalidate: inv_start request, inv_busy status, inv_done pulse.
// ---------------------------------------------------------------------------
interface tag_store_ctrl_if #(
  parameter int TAG_W = 22,
  parameter int SETS  = 64,
  parameter int WAYS  = 2
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             lk_valid;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;

  logic             rs_valid;
  logic             rs_hit;
  logic [WAY_W-1:0] rs_way;
  logic [WAY_W-1:0] rs_victim;

  logic             fill_en;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;

  logic             inv_start;
  logic             inv_busy;
  logic             inv_done;

  modport master (
    output lk_valid, lk_index, lk_tag,
    output fill_en, fill_index, fill_way, fill_tag,
    output inv_start,
    input  lk_ready, rs_valid, rs_hit, rs_way, rs_victim,
    input  inv_busy, inv_done
  );

  modport slave (
    input  lk_valid, lk_index, lk_tag,
    input  fill_en, fill_index, fill_way, fill_tag,
    input  inv_start,
    output lk_ready, rs_valid, rs_hit, rs_way, rs_victim,
    output inv_busy, inv_done
  );
endinterface

// File: rtl/tag_store_ctrl.sv
// ---------------------------------------------------------------------------
// tag_store_ctrl
// Flop-based multi-way cache tag store: per-entry valid bits, registered
// hit/miss lookup with victim selection, single-cycle fill writes and a
// sequential invalidate-all sweep (one set per cycle).
// Ports:
//   CK   - clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - tag_store_ctrl_if.slave (lookup, result, fill, invalidate)
// ---------------------------------------------------------------------------
module tag_store_ctrl #(
  parameter int TAG_W = 22,
  parameter int SETS  = 64,
  parameter int WAYS  = 2
) (
  input logic             CK,
  input logic             rstn,
  tag_store_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Control state
  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             lk_ready_q;
  logic             inv_busy_q;
  logic             inv_done_q;

  // Result registers
  logic             rs_valid_q;
  logic             rs_hit_q;
  logic [WAY_W-1:0] rs_way_q;
  logic [WAY_W-1:0] rs_victim_q;

  // Storage: tags are never reset, valid bits and pointers are
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] ptr_q   [SETS];

  logic             lk_acc_s;
  logic             fill_acc_s;
  logic [WAYS-1:0]  match_s;
  logic             hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] victim_s;
  logic [WAY_W-1:0] ptr_next_s;

  assign lk_acc_s   = bus.lk_valid & lk_ready_q;
  // Fills are only honoured while no sweep is in progress
  assign fill_acc_s = bus.fill_en & (state_q == ST_IDLE);
  // With one way the pointer stays 0; otherwise the add wraps naturally
  assign ptr_next_s = (WAYS == 1) ? '0 : (bus.fill_way + WAY_W'(1));

  // Lookup compare and victim pick against the pre-fill contents of the set
  always_comb begin
    match_s   = '0;
    hit_way_s = '0;
    victim_s  = ptr_q[bus.lk_index];
    // Descending scan so the lowest matching / lowest invalid way wins.
    // Tag compare is gated by valid so unwritten tags never reach outputs.
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s[w] = valid_q[bus.lk_index][w] ? (tag_q[bus.lk_index][w] == bus.lk_tag) : 1'b0;
      hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
      victim_s   = valid_q[bus.lk_index][w] ? victim_s : WAY_W'(w);
    end
    hit_s = |match_s;
  end

  // Tag array write port (no reset: contents are qualified by valid_q)
  always_ff @(posedge CK) begin
    if (fill_acc_s) begin
      tag_q[bus.fill_index][bus.fill_way] <= bus.fill_tag;
    end
  end

  // Valid bits and round-robin pointers: cleared by sweep, set by fills
  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (state_q == ST_SWEEP) begin
      valid_q[cnt_q] <= '0;
      ptr_q[cnt_q]   <= '0;
    end else if (fill_acc_s) begin
      valid_q[bus.fill_index][bus.fill_way] <= 1'b1;
      ptr_q[bus.fill_index]                 <= ptr_next_s;
    end
  end

  // Invalidate-all FSM with registered status outputs
  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lk_ready_q <= 1'b1;
      inv_busy_q <= 1'b0;
      inv_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          inv_done_q <= 1'b0;
          if (bus.inv_start) begin
            state_q    <= ST_SWEEP;
            cnt_q      <= '0;
            inv_busy_q <= 1'b1;
            lk_ready_q <= 1'b0;
          end
        end
        ST_SWEEP: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_q    <= ST_DONE;
            inv_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          inv_done_q <= 1'b0;
          inv_busy_q <= 1'b0;
          lk_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          inv_done_q <= 1'b0;
          inv_busy_q <= 1'b0;
          lk_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Lookup result registers; payload holds between strobes
  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      rs_valid_q  <= 1'b0;
      rs_hit_q    <= 1'b0;
      rs_way_q    <= '0;
      rs_victim_q <= '0;
    end else begin
      rs_valid_q <= lk_acc_s;
      if (lk_acc_s) begin
        rs_hit_q    <= hit_s;
        rs_way_q    <= hit_way_s;
        rs_victim_q <= victim_s;
      end
    end
  end

  assign bus.lk_ready  = lk_ready_q;
  assign bus.rs_valid  = rs_valid_q;
  assign bus.rs_hit    = rs_hit_q;
  assign bus.rs_way    = rs_way_q;
  assign bus.rs_victim = rs_victim_q;
  assign bus.inv_busy  = inv_busy_q;
  assign bus.inv_done  = inv_done_q;

endmodule

// File: tb/tb_tag_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tag_store_ctrl
// Scoreboard bench for tag_store_ctrl: every lookup pushes its expected
// result; a negedge monitor pops and compares on each rs_valid strobe.
// ---------------------------------------------------------------------------
module tb_tag_store_ctrl;
  localparam int TAG_W = 22;
  localparam int SETS  = 64;
  localparam int WAYS  = 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = 1;

  logic CK   = 1'b0;
  logic rstn = 1'b0;

  always #5 CK = ~CK;

  tag_store_ctrl_if #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) bus ();

  tag_store_ctrl #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .CK   (CK),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] victim;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Result monitor: compare every strobe against the oldest expectation
  always @(negedge CK) begin
    if (rstn && bus.rs_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_rs_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("rs_hit",    {31'd0, bus.rs_hit},    {31'd0, mon_e.hit});
        check_val("rs_way",    {31'd0, bus.rs_way},    {31'd0, mon_e.way});
        check_val("rs_victim", {31'd0, bus.rs_victim}, {31'd0, mon_e.victim});
      end
    end
  end

  // Return inputs to idle one step after the next rising edge
  task automatic step();
    @(posedge CK);
    #1;
    bus.lk_valid  = 1'b0;
    bus.fill_en   = 1'b0;
    bus.inv_start = 1'b0;
  endtask

  task automatic drive_lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                              input logic eh, input logic [WAY_W-1:0] ew, input logic [WAY_W-1:0] ev);
    exp_t e;
    bus.lk_valid = 1'b1;
    bus.lk_index = idx;
    bus.lk_tag   = tag;
    e.hit = eh; e.way = ew; e.victim = ev;
    exp_q.push_back(e);
  endtask

  task automatic drive_fill(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                            input logic [TAG_W-1:0] tag);
    bus.fill_en    = 1'b1;
    bus.fill_index = idx;
    bus.fill_way   = way;
    bus.fill_tag   = tag;
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic eh, input logic [WAY_W-1:0] ew, input logic [WAY_W-1:0] ev);
    drive_lookup(idx, tag, eh, ew, ev);
    step();
  endtask

  task automatic do_fill(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                         input logic [TAG_W-1:0] tag);
    drive_fill(idx, way, tag);
    step();
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int busy_cycles, done_pulses, done_at, ready_bad, finished, dp;

  initial begin
    bus.lk_valid   = 1'b0;
    bus.lk_index   = '0;
    bus.lk_tag     = '0;
    bus.fill_en    = 1'b0;
    bus.fill_index = '0;
    bus.fill_way   = '0;
    bus.fill_tag   = '0;
    bus.inv_start  = 1'b0;

    // Reset values
    #12;
    check_val("rst_rs_valid",  {31'd0, bus.rs_valid},  32'd0);
    check_val("rst_rs_hit",    {31'd0, bus.rs_hit},    32'd0);
    check_val("rst_rs_way",    {31'd0, bus.rs_way},    32'd0);
    check_val("rst_rs_victim", {31'd0, bus.rs_victim}, 32'd0);
    check_val("rst_inv_busy",  {31'd0, bus.inv_busy},  32'd0);
    check_val("rst_inv_done",  {31'd0, bus.inv_done},  32'd0);
    check_val("rst_lk_ready",  {31'd0, bus.lk_ready},  32'd1);
    @(negedge CK);
    rstn = 1'b1;
    @(posedge CK);
    #1;

    // Cold miss, then hit after fill, then miss with way1 as victim
    do_lookup(6'd5, 22'h1234, 1'b0, 1'b0, 1'b0);
    do_fill  (6'd5, 1'b0, 22'h1234);
    do_lookup(6'd5, 22'h1234, 1'b1, 1'b0, 1'b1);
    do_lookup(6'd5, 22'h1235, 1'b0, 1'b0, 1'b1);

    // Round-robin pointer wrap in set 9
    do_fill  (6'd9, 1'b0, 22'h0AAAA);
    do_fill  (6'd9, 1'b1, 22'h0BBBB);
    do_lookup(6'd9, 22'h0CCCC, 1'b0, 1'b0, 1'b0);
    do_lookup(6'd9, 22'h0BBBB, 1'b1, 1'b1, 1'b0);
    do_fill  (6'd9, 1'b0, 22'h0DDDD);
    do_lookup(6'd9, 22'h0CCCC, 1'b0, 1'b0, 1'b1);

    // Same-cycle fill and lookup: lookup sees pre-fill contents
    drive_fill  (6'd3, 1'b1, 22'h0ABC);
    drive_lookup(6'd3, 22'h0ABC, 1'b0, 1'b0, 1'b0);
    step();
    do_lookup(6'd3, 22'h0ABC, 1'b1, 1'b1, 1'b0);

    // Duplicate tag in both ways: lowest way reported
    do_fill  (6'd7, 1'b0, 22'h77);
    do_fill  (6'd7, 1'b1, 22'h77);
    do_lookup(6'd7, 22'h77, 1'b1, 1'b0, 1'b0);

    // Populate sets 0 and 63 before the sweep
    do_fill  (6'd0, 1'b0, 22'h100);
    do_fill  (6'd63, 1'b1, 22'h3F3F);
    do_lookup(6'd63, 22'h3F3F, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge CK);
    #1;

    // Invalidate-all sweep with fills, lookups and re-starts attempted meanwhile
    bus.inv_start = 1'b1;
    @(posedge CK);
    #1;
    drive_fill(6'd0, 1'b1, 22'h0BEEF);
    bus.lk_valid = 1'b1;
    bus.lk_index = 6'd0;
    bus.lk_tag   = 22'h111;
    busy_cycles = 0; done_pulses = 0; done_at = 0; ready_bad = 0; finished = 0;
    for (int c = 1; c <= 200 && finished == 0; c++) begin
      @(negedge CK);
      if (bus.inv_busy) busy_cycles++;
      else finished = 1;
      if (bus.inv_done) begin
        done_pulses++;
        done_at = c;
      end
      if (bus.lk_ready !== !bus.inv_busy) ready_bad++;
    end
    bus.inv_start = 1'b0;
    bus.fill_en   = 1'b0;
    bus.lk_valid  = 1'b0;
    check_val("sweep_finished",    finished,    32'd1);
    check_val("sweep_busy_cycles", busy_cycles, 32'd65);
    check_val("sweep_done_pulses", done_pulses, 32'd1);
    check_val("sweep_done_cycle",  done_at,     32'd65);
    check_val("sweep_lk_ready",    ready_bad,   32'd0);
    @(posedge CK);
    #1;
    check_val("post_sweep_busy", {31'd0, bus.inv_busy}, 32'd0);
    do_lookup(6'd0,  22'h100,   1'b0, 1'b0, 1'b0);
    do_lookup(6'd63, 22'h3F3F,  1'b0, 1'b0, 1'b0);
    do_lookup(6'd0,  22'h0BEEF, 1'b0, 1'b0, 1'b0);
    do_lookup(6'd9,  22'h0DDDD, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CK);
    #1;

    // Reset in the middle of a sweep
    bus.inv_start = 1'b1;
    step();
    repeat (10) @(posedge CK);
    #1;
    check_val("midsweep_busy_before", {31'd0, bus.inv_busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check_val("midrst_inv_busy", {31'd0, bus.inv_busy}, 32'd0);
    check_val("midrst_lk_ready", {31'd0, bus.lk_ready}, 32'd1);
    check_val("midrst_rs_valid", {31'd0, bus.rs_valid}, 32'd0);
    check_val("midrst_rs_hit",   {31'd0, bus.rs_hit},   32'd0);
    dp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CK);
      if (bus.inv_done) dp++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge CK);
      if (bus.inv_done || bus.inv_busy) dp++;
    end
    check_val("midrst_no_done",      dp, 32'd0);
    check_val("midrst_lk_ready_rel", {31'd0, bus.lk_ready}, 32'd1);
    @(posedge CK);
    #1;
    do_lookup(6'd5, 22'h1234, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CK);
    #1;
    check_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
